// File: rtl/demux_1x2_stream.sv
// demux_1x2_stream: routes one ready/valid input stream into two independent output FIFOs.
//
// Ports:
//   clk, rst_n                  single clock, asynchronous active-low reset
//   sel                         destination of the current input word (0 -> ch0, 1 -> ch1)
//   in_valid, in_data, in_ready input handshake; in_ready reflects only the selected FIFO
//   outK_valid, outK_data       head of channel K FIFO (registered storage)
//   outK_ready                  downstream consumes the channel K head word
//   count0, count1              occupancy of each channel FIFO
module demux_1x2_stream #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         sel,
  input  logic                         in_valid,
  input  logic [WIDTH-1:0]             in_data,
  output logic                         in_ready,
  output logic                         out0_valid,
  output logic [WIDTH-1:0]             out0_data,
  input  logic                         out0_ready,
  output logic                         out1_valid,
  output logic [WIDTH-1:0]             out1_data,
  input  logic                         out1_ready,
  output logic [$clog2(DEPTH+1)-1:0]   count0,
  output logic [$clog2(DEPTH+1)-1:0]   count1
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);

  logic [1:0]       full;
  logic [1:0]       valid_v;
  logic [1:0]       ready_v;
  logic [1:0]       push;
  logic [1:0]       pop;
  logic [WIDTH-1:0] head [2];
  logic [CW-1:0]    cnt  [2];

  assign ready_v = {out1_ready, out0_ready};

  // No bypass: a full FIFO stays not-ready even if it pops this cycle.
  assign in_ready = ~full[sel];

  for (genvar k = 0; k < 2; k++) begin : g_ch
    logic [PW-1:0]    wptr_q, wptr_d;
    logic [PW-1:0]    rptr_q, rptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] mem_q [DEPTH];

    assign full[k]    = (cnt_q == CW'(DEPTH));
    assign valid_v[k] = (cnt_q != '0);
    assign push[k]    = in_valid & in_ready & (sel == 1'(k));
    assign pop[k]     = valid_v[k] & ready_v[k];

    // DEPTH is a power of two, so pointer increments wrap naturally.
    always_comb begin
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      cnt_d  = cnt_q;
      if (push[k]) wptr_d = wptr_q + 1'b1;
      if (pop[k])  rptr_d = rptr_q + 1'b1;
      case ({push[k], pop[k]})
        2'b10:   cnt_d = cnt_q + 1'b1;
        2'b01:   cnt_d = cnt_q - 1'b1;
        default: cnt_d = cnt_q;
      endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        wptr_q <= '0;
        rptr_q <= '0;
        cnt_q  <= '0;
      end else begin
        wptr_q <= wptr_d;
        rptr_q <= rptr_d;
        cnt_q  <= cnt_d;
      end
    end

    // Storage is not reset; stale entries are unreachable once pointers clear.
    always_ff @(posedge clk) begin
      if (push[k]) mem_q[wptr_q] <= in_data;
    end

    assign head[k] = mem_q[rptr_q];
    assign cnt[k]  = cnt_q;
  end

  assign out0_valid = valid_v[0];
  assign out1_valid = valid_v[1];
  assign out0_data  = head[0];
  assign out1_data  = head[1];
  assign count0     = cnt[0];
  assign count1     = cnt[1];

endmodule
